// File: rtl/cnn_layer_accel_sched_pkg.sv
// Shared types and helpers for the quad-side job schedulers.
package cnn_layer_accel_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StFetch,
    StRun,
    StCmpl,
    StDone
  } sched_state_t;

  // Default number of cycles a job may sit in ISSUE or RUN before it is aborted.
  localparam int unsigned CTimeoutDefault = 65535;

  // Width of an index selecting one of num_req requesters (at least 1 bit).
  function automatic int unsigned owner_w(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/cnl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the pointer, wrapping.
// The pointer moves to the granted index only when the caller strobes advance_i.
module cnl_rr_arbiter
  import cnn_layer_accel_sched_pkg::*;
#(
  parameter int unsigned C_NUM_REQ = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [C_NUM_REQ-1:0]             req_i,
  input  logic                             advance_i,
  output logic [C_NUM_REQ-1:0]             grant_o,
  output logic [owner_w(C_NUM_REQ)-1:0]    idx_o,
  output logic                             valid_o
);

  localparam int unsigned IdxW = owner_w(C_NUM_REQ);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] cand;

  // Scan requesters starting just after the pointer; first hit wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= C_NUM_REQ; k++) begin
      cand = IdxW'((32'(ptr_q) + k) % C_NUM_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

  // Pointer follows the last accepted grant.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && valid_o) begin
      ptr_d = idx_o;
    end
  end

  // Pointer register; resets to the last index so requester 0 wins first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= IdxW'(C_NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cnn_layer_accel_job_sched.sv
// Job scheduler in front of one cnn_layer_accel_quad: shares the quad job port among
// requesters round-robin, sequences the quad handshake and routes events to the owner.
module cnn_layer_accel_job_sched
  import cnn_layer_accel_sched_pkg::*;
#(
  parameter int unsigned C_NUM_REQ = 4,
  parameter int unsigned C_PARAM_W = 128,
  parameter int unsigned C_TIMEOUT = CTimeoutDefault
) (
  input  logic                             clk_if_i,
  input  logic                             rst_ni,
  input  logic [C_NUM_REQ-1:0]             req_valid_i,
  output logic [C_NUM_REQ-1:0]             req_ready_o,
  input  logic [C_NUM_REQ*C_PARAM_W-1:0]   req_parameters_i,
  output logic [C_NUM_REQ-1:0]             fwd_fetch_request_o,
  input  logic [C_NUM_REQ-1:0]             fwd_fetch_ack_i,
  input  logic [C_NUM_REQ-1:0]             fwd_fetch_complete_i,
  output logic [C_NUM_REQ-1:0]             done_valid_o,
  output logic                             done_err_o,
  input  logic [C_NUM_REQ-1:0]             done_ack_i,
  output logic                             job_start_o,
  input  logic                             job_accept_i,
  output logic [C_PARAM_W-1:0]             job_parameters_o,
  input  logic                             job_fetch_request_i,
  output logic                             job_fetch_ack_o,
  output logic                             job_fetch_complete_o,
  input  logic                             job_complete_i,
  output logic                             job_complete_ack_o,
  output logic                             busy_o,
  output logic [owner_w(C_NUM_REQ)-1:0]    owner_id_o
);

  localparam int unsigned OwnerW = owner_w(C_NUM_REQ);
  localparam int unsigned TimerW = $clog2(C_TIMEOUT + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(C_TIMEOUT - 1);
  localparam logic [TimerW-1:0] TimerSat  = TimerW'(C_TIMEOUT);

  sched_state_t          state_q, state_d;
  logic [OwnerW-1:0]     owner_q, owner_d;
  logic [C_PARAM_W-1:0]  param_q, param_d;
  logic                  err_q, err_d;
  logic [TimerW-1:0]     timer_q, timer_d;

  logic [C_NUM_REQ-1:0]  arb_grant;
  logic [OwnerW-1:0]     arb_idx;
  logic                  arb_valid;
  logic                  arb_adv;
  logic [C_PARAM_W-1:0]  arb_params;
  logic                  timeout;
  logic                  in_fetch;

  cnl_rr_arbiter #(
    .C_NUM_REQ (C_NUM_REQ)
  ) u_arb (
    .clk_i     (clk_if_i),
    .rst_ni    (rst_ni),
    .req_i     (req_valid_i),
    .advance_i (arb_adv),
    .grant_o   (arb_grant),
    .idx_o     (arb_idx),
    .valid_o   (arb_valid)
  );

  // One-hot select of the granted requester's descriptor.
  always_comb begin
    arb_params = '0;
    for (int i = 0; i < int'(C_NUM_REQ); i++) begin
      if (arb_grant[i]) begin
        arb_params = req_parameters_i[i*C_PARAM_W +: C_PARAM_W];
      end
    end
  end

  assign timeout  = (timer_q >= TimerLast);
  assign in_fetch = (state_q == StFetch);

  // Next-state logic; handshake inputs outside their states fall through to hold.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    param_d = param_q;
    err_d   = err_q;
    arb_adv = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          arb_adv = 1'b1;
          owner_d = arb_idx;
          param_d = arb_params;
          err_d   = 1'b0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // An accept in the timeout cycle still wins: the quad has taken the job.
        if (job_accept_i) begin
          state_d = StFetch;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StFetch: begin
        if (job_complete_i) begin
          state_d = StCmpl;
        end else if (fwd_fetch_complete_i[owner_q]) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (job_complete_i) begin
          state_d = StCmpl;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StCmpl: begin
        state_d = StDone;
      end
      StDone: begin
        if (done_ack_i[owner_q]) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Timer restarts on every state change and only advances in ISSUE and RUN.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if ((state_q == StIssue || state_q == StRun) && timer_q != TimerSat) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // State, owner, latched descriptor, error flag and timer.
  always_ff @(posedge clk_if_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      owner_q <= '0;
      param_q <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      param_q <= param_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  // Per-requester routing of ready, fetch request and done to the owner only.
  always_comb begin
    req_ready_o         = '0;
    fwd_fetch_request_o = '0;
    done_valid_o        = '0;
    for (int i = 0; i < int'(C_NUM_REQ); i++) begin
      req_ready_o[i]         = (state_q == StIdle) && arb_grant[i];
      fwd_fetch_request_o[i] = in_fetch && (owner_q == OwnerW'(i)) && job_fetch_request_i;
      done_valid_o[i]        = (state_q == StDone) && (owner_q == OwnerW'(i));
    end
  end

  assign job_fetch_ack_o      = in_fetch & fwd_fetch_ack_i[owner_q] & job_fetch_request_i;
  assign job_fetch_complete_o = in_fetch & fwd_fetch_complete_i[owner_q];
  assign job_start_o          = (state_q == StIssue);
  assign job_parameters_o     = param_q;
  assign job_complete_ack_o   = (state_q == StCmpl);
  assign done_err_o           = (state_q == StDone) & err_q;
  assign busy_o               = (state_q != StIdle);
  assign owner_id_o           = owner_q;

endmodule
